// File: rtl/umai_traffic_gen_if.sv
// UMAI command/data bundle between the traffic generator (master) and the
// AIB slave-side port. Write command, write data, read command, read data.
interface umai_traffic_gen_if #(
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 6,
    parameter int DataWidth = 512
);
    logic                 wcmd_valid;
    logic                 wcmd_ready;
    logic [AddrWidth-1:0] wcmd_addr;
    logic [LenWidth-1:0]  wcmd_len;
    logic                 wvalid;
    logic                 wready;
    logic [DataWidth-1:0] wdata;
    logic                 rcmd_valid;
    logic                 rcmd_ready;
    logic [AddrWidth-1:0] rcmd_addr;
    logic [LenWidth-1:0]  rcmd_len;
    logic                 rvalid;
    logic                 rready;
    logic [DataWidth-1:0] rdata;

    modport master (
        output wcmd_valid, wcmd_addr, wcmd_len, wvalid, wdata,
               rcmd_valid, rcmd_addr, rcmd_len, rready,
        input  wcmd_ready, wready, rcmd_ready, rvalid, rdata
    );

    modport slave (
        input  wcmd_valid, wcmd_addr, wcmd_len, wvalid, wdata,
               rcmd_valid, rcmd_addr, rcmd_len, rready,
        output wcmd_ready, wready, rcmd_ready, rvalid, rdata
    );
endinterface

// File: rtl/umai_traffic_gen.sv
// UMAI master traffic generator/checker for AIB channel bring-up.
// Issues a programmed number of write bursts, each followed by a read-back
// of the same address range; every read beat is compared against the
// pattern that was written and mismatches are counted (saturating).
// Optional macro UMAI_TG_LFSR_EN: pattern comes from a 32-bit Galois LFSR
// instead of the seed/burst/beat counter pattern.
module umai_traffic_gen #(
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 6,
    parameter int DataWidth = 512,
    parameter int CntWidth  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [AddrWidth-1:0] i_base_addr,
    input  logic [LenWidth-1:0]  i_len,
    input  logic [CntWidth-1:0]  i_num_bursts,
    input  logic [31:0]          i_seed,
    umai_traffic_gen_if.master   bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [CntWidth-1:0]  o_err_cnt
);
    localparam int Words = DataWidth / 32;
    localparam int Bytes = DataWidth / 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WCMD  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RCMD  = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]           state;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  len_q;
    logic [LenWidth-1:0]  k_q;
    logic [CntWidth-1:0]  last_q;
    logic [CntWidth-1:0]  b_q;
    logic [CntWidth-1:0]  err_q;
    logic [31:0]          wword_q;
    logic [31:0]          cword_q;
    logic                 wcmd_valid_q;
    logic                 wvalid_q;
    logic                 rcmd_valid_q;
    logic                 rready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
`ifdef UMAI_TG_LFSR_EN
    logic [31:0]          snap_q;   // writer LFSR value at the start of the current burst
`else
    logic [31:0]          seed_q;
`endif

    // Step of the pattern generator: Galois LFSR (taps 32,22,2,1) or +1.
    function automatic logic [31:0] next_word(input logic [31:0] w);
`ifdef UMAI_TG_LFSR_EN
        next_word = {1'b0, w[31:1]} ^ (w[0] ? 32'h8020_0003 : 32'h0000_0000);
`else
        next_word = w + 32'd1;
`endif
    endfunction

    logic                 start_ok;
    logic [AddrWidth-1:0] stride;
    logic [CntWidth-1:0]  b_next;
    logic [CntWidth-1:0]  err_next;
    logic                 k_last;
    logic                 w_hs;
    logic                 r_beat;
    logic                 mismatch;

    // Handshake qualifiers, burst stride and the next error count.
    always_comb begin
        start_ok = i_start && (state == IDLE || state == DONE);
        stride   = (AddrWidth'(len_q) + AddrWidth'(1)) * AddrWidth'(Bytes);
        b_next   = b_q + CntWidth'(1);
        k_last   = (k_q == len_q);
        w_hs     = wvalid_q && bus.wready;
        r_beat   = rready_q && bus.rvalid;   // rready is only high in RDATA
        mismatch = (bus.rdata != {Words{cword_q}});
        err_next = err_q;
        if (r_beat && mismatch && (err_q != {CntWidth{1'b1}}))
            err_next = err_q + CntWidth'(1);
    end

    // Sequencer: write burst, read-back burst, repeat, then hold DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            k_q          <= '0;
            last_q       <= '0;
            b_q          <= '0;
            err_q        <= '0;
            wword_q      <= '0;
            cword_q      <= '0;
            wcmd_valid_q <= 1'b0;
            wvalid_q     <= 1'b0;
            rcmd_valid_q <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef UMAI_TG_LFSR_EN
            snap_q       <= '0;
`else
            seed_q       <= '0;
`endif
        end else if (start_ok) begin
            addr_q       <= i_base_addr;
            len_q        <= i_len;
            last_q       <= (i_num_bursts == '0) ? '0 : i_num_bursts - CntWidth'(1);
            b_q          <= '0;
            k_q          <= '0;
            err_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            wcmd_valid_q <= 1'b1;
            state        <= WCMD;
`ifdef UMAI_TG_LFSR_EN
            wword_q      <= (i_seed == 32'd0) ? 32'd1 : i_seed;
`else
            seed_q       <= i_seed;
            wword_q      <= i_seed;
`endif
        end else begin
            case (state)
                WCMD: if (bus.wcmd_ready) begin
                    wcmd_valid_q <= 1'b0;
                    wvalid_q     <= 1'b1;
                    state        <= WDATA;
`ifdef UMAI_TG_LFSR_EN
                    snap_q       <= wword_q;
`endif
                end
                WDATA: if (w_hs) begin
                    wword_q <= next_word(wword_q);
                    if (k_last) begin
                        k_q          <= '0;
                        wvalid_q     <= 1'b0;
                        rcmd_valid_q <= 1'b1;
                        state        <= RCMD;
                    end else begin
                        k_q <= k_q + LenWidth'(1);
                    end
                end
                RCMD: if (bus.rcmd_ready) begin
                    rcmd_valid_q <= 1'b0;
                    rready_q     <= 1'b1;
                    state        <= RDATA;
`ifdef UMAI_TG_LFSR_EN
                    cword_q      <= snap_q;
`else
                    cword_q      <= seed_q + (32'(b_q) << 8);
`endif
                end
                RDATA: if (r_beat) begin
                    err_q   <= err_next;
                    cword_q <= next_word(cword_q);
                    if (k_last) begin
                        k_q      <= '0;
                        rready_q <= 1'b0;
                        if (b_q == last_q) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_next == '0);
                        end else begin
                            b_q          <= b_next;
                            addr_q       <= addr_q + stride;
                            wcmd_valid_q <= 1'b1;
                            state        <= WCMD;
`ifndef UMAI_TG_LFSR_EN
                            wword_q      <= seed_q + (32'(b_next) << 8);
`endif
                        end
                    end else begin
                        k_q <= k_q + LenWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wcmd_valid = wcmd_valid_q;
    assign bus.wcmd_addr  = addr_q;
    assign bus.wcmd_len   = len_q;
    assign bus.wvalid     = wvalid_q;
    assign bus.wdata      = {Words{wword_q}};
    assign bus.rcmd_valid = rcmd_valid_q;
    assign bus.rcmd_addr  = addr_q;
    assign bus.rcmd_len   = len_q;
    assign bus.rready     = rready_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_pass         = pass_q;
    assign o_err_cnt      = err_q;
endmodule

// File: tb/tb_umai_traffic_gen.sv
// Bench for umai_traffic_gen: loopback memory slave with optional ready
// stalls and read corruption, scoreboard of expected command addresses and
// write words, plus a second instance (4-bit counters) for saturation.
module tb_umai_traffic_gen;
    localparam int AW = 32, LW = 6, DW = 512, CW = 16, BYTES = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic [CW-1:0] num_bursts;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [CW-1:0] err_cnt;

    umai_traffic_gen_if #(.AddrWidth(AW), .LenWidth(LW), .DataWidth(DW)) bus ();
    umai_traffic_gen #(.AddrWidth(AW), .LenWidth(LW), .DataWidth(DW), .CntWidth(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_len(len), .i_num_bursts(num_bursts), .i_seed(seed), .bus(bus),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt)
    );

    // saturation instance: slave always ready and returns all-zero read data
    logic       s_start;
    logic       s_busy, s_done, s_pass;
    logic [3:0] s_err;
    umai_traffic_gen_if #(.AddrWidth(AW), .LenWidth(LW), .DataWidth(DW)) sbus ();
    umai_traffic_gen #(.AddrWidth(AW), .LenWidth(LW), .DataWidth(DW), .CntWidth(4)) sdut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_base_addr(32'h0000_1000),
        .i_len(6'd63), .i_num_bursts(4'd1), .i_seed(32'd1), .bus(sbus),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_err_cnt(s_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    cmd_t          wq[$], rq[$];
    logic [AW-1:0] exp_waddr[$], exp_raddr[$];
    logic [31:0]   exp_word[$];
    logic [LW-1:0] exp_len;
    logic [DW-1:0] mem [logic [AW-1:0]];
    int  wbeat = 0, rbeat = 0, rburst = 0;
    int  n_wcmd = 0, n_wbeat = 0, n_rbeat = 0;
    bit  stall_en = 0, corrupt_en = 0;
    int  cor_burst = 0, cor_beat = 0;
    bit  pw_cmd = 0, pw_dat = 0, pr_cmd = 0;
    logic [AW-1:0] p_waddr, p_raddr;
    logic [DW-1:0] p_wdata;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

`ifdef UMAI_TG_LFSR_EN
    function automatic logic [31:0] lfsr_step(input logic [31:0] w);
        return {1'b0, w[31:1]} ^ (w[0] ? 32'h8020_0003 : 32'h0);
    endfunction
`endif

    // expected command addresses and write words for a whole sequence
    task automatic push_exp(input logic [AW-1:0] b, input int l, input int nb, input logic [31:0] s);
        int n = (nb == 0) ? 1 : nb;
        logic [31:0] w = (s == 32'd0) ? 32'd1 : s;
        exp_len = LW'(l);
        for (int bb = 0; bb < n; bb++) begin
            exp_waddr.push_back(b + AW'(bb * (l + 1) * BYTES));
            exp_raddr.push_back(b + AW'(bb * (l + 1) * BYTES));
            for (int k = 0; k <= l; k++) begin
`ifdef UMAI_TG_LFSR_EN
                exp_word.push_back(w);
                w = lfsr_step(w);
`else
                exp_word.push_back(s + (32'(bb) << 8) + 32'(k));
`endif
            end
        end
    endtask

    // slave model and monitor; decides readys/rvalid on the falling edge, so
    // a handshake at the next rising edge is known here
    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.wcmd_ready = 1'b0; bus.wready = 1'b0; bus.rcmd_ready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.wcmd_ready = 1'b0; bus.wready = 1'b0; bus.rcmd_ready = 1'b0;
                bus.rvalid = 1'b0;
                pw_cmd = 0; pw_dat = 0; pr_cmd = 0;
            end else begin
                if (pw_cmd) begin
                    chk("wcmd_valid_hold", bus.wcmd_valid, 1'b1);
                    chk("wcmd_addr_hold", bus.wcmd_addr, p_waddr);
                end
                if (pw_dat) begin
                    chk("wvalid_hold", bus.wvalid, 1'b1);
                    chk("wdata_hold", bus.wdata, p_wdata);
                end
                if (pr_cmd) begin
                    chk("rcmd_valid_hold", bus.rcmd_valid, 1'b1);
                    chk("rcmd_addr_hold", bus.rcmd_addr, p_raddr);
                end
                // write command
                bus.wcmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.wcmd_valid && bus.wcmd_ready) begin
                    n_wcmd++;
                    if (exp_waddr.size() == 0) chk("wcmd_unexpected", 1'b1, 1'b0);
                    else chk("wcmd_addr", bus.wcmd_addr, exp_waddr.pop_front());
                    chk("wcmd_len", bus.wcmd_len, exp_len);
                    wq.push_back('{addr: bus.wcmd_addr, len: bus.wcmd_len});
                end
                pw_cmd = bus.wcmd_valid && !bus.wcmd_ready;
                p_waddr = bus.wcmd_addr;
                // write data
                bus.wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.wvalid) begin
                    if (wq.size() == 0) chk("wdata_before_cmd", 1'b1, 1'b0);
                    else if (bus.wready) begin
                        if (exp_word.size() == 0) chk("wdata_unexpected", 1'b1, 1'b0);
                        else chk("wdata", bus.wdata, {(DW/32){exp_word.pop_front()}});
                        mem[wq[0].addr + AW'(wbeat * BYTES)] = bus.wdata;
                        wbeat++; n_wbeat++;
                        if (wbeat > int'(wq[0].len)) begin
                            wbeat = 0;
                            void'(wq.pop_front());
                        end
                    end
                end
                pw_dat = bus.wvalid && !bus.wready;
                p_wdata = bus.wdata;
                // read command
                bus.rcmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.rcmd_valid && bus.rcmd_ready) begin
                    if (exp_raddr.size() == 0) chk("rcmd_unexpected", 1'b1, 1'b0);
                    else chk("rcmd_addr", bus.rcmd_addr, exp_raddr.pop_front());
                    chk("rcmd_len", bus.rcmd_len, exp_len);
                    rq.push_back('{addr: bus.rcmd_addr, len: bus.rcmd_len});
                end
                pr_cmd = bus.rcmd_valid && !bus.rcmd_ready;
                p_raddr = bus.rcmd_addr;
                // read data (may be presented before rready rises; must be ignored)
                if (rq.size() != 0) begin
                    bus.rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                    a = rq[0].addr + AW'(rbeat * BYTES);
                    d = mem.exists(a) ? mem[a] : '0;
                    if (corrupt_en && rburst == cor_burst && rbeat == cor_beat) d[0] = ~d[0];
                    bus.rdata = d;
                    if (bus.rvalid && bus.rready) begin
                        rbeat++; n_rbeat++;
                        if (rbeat > int'(rq[0].len)) begin
                            rbeat = 0; rburst++;
                            void'(rq.pop_front());
                        end
                    end
                end else begin
                    bus.rvalid = 1'b0;
                end
            end
        end
    end

    task automatic clear_counts();
        n_wcmd = 0; n_wbeat = 0; n_rbeat = 0; rburst = 0; wbeat = 0; rbeat = 0;
    endtask

    task automatic kick(input logic [AW-1:0] b, input int l, input int nb, input logic [31:0] s);
        @(negedge clk);
        push_exp(b, l, nb, s);
        base_addr = b; len = LW'(l); num_bursts = CW'(nb); seed = s;
        start = 1'b1;
        @(posedge clk); #1;
        chk("cmd_latency", bus.wcmd_valid, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_done_clr", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_sb_empty"}, exp_waddr.size() + exp_raddr.size() + exp_word.size(), 0);
    endtask

    initial begin
        int c;
        start = 1'b0; base_addr = '0; len = '0; num_bursts = '0; seed = '0; s_start = 1'b0;
        sbus.wcmd_ready = 1'b1; sbus.wready = 1'b1; sbus.rcmd_ready = 1'b1;
        sbus.rvalid = 1'b1; sbus.rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_wcmd_valid", bus.wcmd_valid, 1'b0);
        chk("rst_wvalid", bus.wvalid, 1'b0);
        chk("rst_rcmd_valid", bus.rcmd_valid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_cnt, 0);
        chk("rst_waddr", bus.wcmd_addr, 0);
        chk("rst_rlen", bus.rcmd_len, 0);
        chk("rst_wdata", bus.wdata, 0);
        rst_n = 1'b1;

        // single beat, single burst
        clear_counts();
        kick(32'hdeadbe00, 0, 1, 32'hdeadbee0);
        wait_done("t1_done", 200);
        chk("t1_pass", pass, 1'b1);
        chk("t1_err", err_cnt, 0);
        chk("t1_wcmds", n_wcmd, 1);

        // 4 bursts of 4 beats, random stalls; base chosen so addresses wrap
        clear_counts();
        stall_en = 1;
        kick(32'hffffff00, 3, 4, $urandom);
        wait_done("t2_done", 3000);
        stall_en = 0;
        chk("t2_pass", pass, 1'b1);
        chk("t2_beats", n_wbeat + n_rbeat, 32);
        chk("t2_wcmds", n_wcmd, 4);

        // one corrupted read beat
        clear_counts();
        corrupt_en = 1; cor_burst = 1; cor_beat = 2;
        kick(32'h0001_0000, 3, 2, 32'h1234_5678);
        wait_done("t3_done", 500);
        corrupt_en = 0;
        chk("t3_err", err_cnt, 1);
        chk("t3_pass", pass, 1'b0);

        // saturating 4-bit error counter
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        c = 0;
        while (!s_done && c < 1000) begin @(negedge clk); c++; end
        chk("sat_done", s_done, 1'b1);
        chk("sat_err", s_err, 4'hf);
        chk("sat_pass", s_pass, 1'b0);

        // async reset during write beat 5
        clear_counts();
        kick(32'h0002_0000, 7, 2, 32'h0000_a000);
        c = 0;
        while (n_wbeat < 5 && c < 200) begin @(negedge clk); #1; c++; end
        @(posedge clk); #2;
        chk("rst_pre_wvalid", bus.wvalid, 1'b1);
        chk("rst_pre_wdata", bus.wdata, {(DW/32){32'h0000_a005}});
        rst_n = 1'b0;
        #1;
        chk("arst_wvalid", bus.wvalid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        exp_waddr.delete(); exp_raddr.delete(); exp_word.delete(); wq.delete(); rq.delete();
        repeat (2) @(negedge clk);
        chk("arst_all_valid", {bus.wcmd_valid, bus.wvalid, bus.rcmd_valid, bus.rready}, 4'b0);
        chk("arst_done", done, 1'b0);
        rst_n = 1'b1;
        clear_counts();
        kick(32'h0003_0000, 1, 2, 32'h5555_0000);
        wait_done("t5_done", 500);
        chk("t5_pass", pass, 1'b1);

        // num_bursts = 0 runs one pair; a start while busy is ignored
        clear_counts();
        kick(32'h0004_0000, 1, 0, 32'h0bad_0000);
        repeat (2) @(negedge clk);
        chk("t6_busy", busy, 1'b1);
        base_addr = 32'h0009_0000; len = 6'd5; num_bursts = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6_done", 500);
        chk("t6_wcmds", n_wcmd, 1);
        chk("t6_beats", n_wbeat + n_rbeat, 4);
        chk("t6_pass", pass, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_done_held", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
